// File: rtl/life_cell_if.sv
// -----------------------------------------------------------------------------
// life_cell_if
//   Bundles the per-cell control, neighbor and status signals of one
//   life_cell_gen site. The array (or a bench) drives the master side; the
//   cell itself uses the slave side.
//
// Parameters
//   N_NEIGHBORS  number of neighbor alive bits (4 = von Neumann, 8 = Moore)
//   SW           cell-state width, must equal the cell's derived state width
//   AGE_W        width of the alive-age counter
//
// Signals
//   ena        advance one generation this cycle
//   load       synchronous load of state_0
//   state_0    initial state applied on load
//   neighbors  alive bits of the adjacent cells
//   state_d    combinational next state (what state_q takes at the next edge)
//   state_q    registered cell state
//   alive      state_q == 1
//   changed    state_q changed on the last ena step
//   age        consecutive generations alive, saturating
// -----------------------------------------------------------------------------
interface life_cell_if #(
  parameter int N_NEIGHBORS = 8,
  parameter int SW          = 1,
  parameter int AGE_W       = 8
);
  logic                   ena;
  logic                   load;
  logic [SW-1:0]          state_0;
  logic [N_NEIGHBORS-1:0] neighbors;
  logic [SW-1:0]          state_d;
  logic [SW-1:0]          state_q;
  logic                   alive;
  logic                   changed;
  logic [AGE_W-1:0]       age;

  modport master (
    output ena, load, state_0, neighbors,
    input  state_d, state_q, alive, changed, age
  );

  modport slave (
    input  ena, load, state_0, neighbors,
    output state_d, state_q, alive, changed, age
  );
endinterface

// File: rtl/life_cell_gen.sv
// -----------------------------------------------------------------------------
// life_cell_gen
//   One site of a life-like cellular automaton. The next state follows the
//   birth/survive rule masks on the number of live neighbors; with STATES > 2
//   it implements the "Generations" family, where a cell that fails to
//   survive walks through dying states 2..STATES-1 before becoming dead,
//   ignoring its neighbors meanwhile. The whole array steps in lockstep on ena.
//
// Optional feature
//   LIFE_CELL_AGE_EN  when defined, an alive-age counter is built; otherwise
//                     age is tied to zero and no age register exists.
//
// Parameters
//   N_NEIGHBORS   neighbor count (4 or 8 typical)
//   STATES        total states, >= 2 (0 dead, 1 alive, 2.. dying)
//   BIRTH_MASK    bit k set: dead cell with k live neighbors is born
//   SURVIVE_MASK  bit k set: alive cell with k live neighbors survives
//   AGE_W         age counter width
//
// Ports
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  life_cell_if slave: ena, load, state_0, neighbors in;
//        state_d, state_q, alive, changed, age out
//   The interface SW parameter must equal max(1, $clog2(STATES)).
// -----------------------------------------------------------------------------
module life_cell_gen #(
  parameter int                     N_NEIGHBORS  = 8,
  parameter int                     STATES       = 2,
  parameter logic [N_NEIGHBORS:0]   BIRTH_MASK   = 9'b000001000,
  parameter logic [N_NEIGHBORS:0]   SURVIVE_MASK = 9'b000001100,
  parameter int                     AGE_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  life_cell_if.slave bus
);

  localparam int CW = $clog2(N_NEIGHBORS + 1);
  localparam int SW = (STATES <= 2) ? 1 : $clog2(STATES);

  localparam logic [SW-1:0] ONE   = SW'(1);
  localparam logic [SW-1:0] LAST  = SW'(STATES - 1);
  // State entered when an alive cell fails to survive.
  localparam logic [SW-1:0] DECAY = (STATES == 2) ? '0 : SW'(2);
  // STATES in one extra bit so the legality test works when STATES == 2**SW.
  localparam logic [SW:0]   STATES_W = (SW + 1)'(STATES);

  logic [CW-1:0] count;
  logic [SW-1:0] rule_next;
  logic [SW-1:0] load_val;
  logic [SW-1:0] cell_q, cell_d;
  logic          changed_q, changed_d;

  // ---------------------------------------------------------------------------
  // Live-neighbor count. Only alive bits reach this bus, so dying neighbors
  // never contribute.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count = '0;
    for (int i = 0; i < N_NEIGHBORS; i++) begin
      count = count + CW'(bus.neighbors[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Rule step. The last dying state and any unused encoding both fall to dead,
  // so an illegal value can never persist.
  // ---------------------------------------------------------------------------
  always_comb begin
    rule_next = '0;
    if (cell_q == '0) begin
      rule_next = BIRTH_MASK[count] ? ONE : '0;
    end else if (cell_q == ONE) begin
      rule_next = SURVIVE_MASK[count] ? ONE : DECAY;
    end else if (cell_q < LAST) begin
      rule_next = cell_q + ONE;
    end
  end

  // Out-of-range load values are clamped to dead.
  assign load_val = ({1'b0, bus.state_0} < STATES_W) ? bus.state_0 : '0;

  // ---------------------------------------------------------------------------
  // Next-state selection: load beats ena; otherwise hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    cell_d    = cell_q;
    changed_d = changed_q;
    if (bus.load) begin
      cell_d    = load_val;
      changed_d = 1'b0;
    end else if (bus.ena) begin
      cell_d    = rule_next;
      changed_d = (rule_next != cell_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, keeping the whole array in lockstep.
    if (rst) begin
      cell_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cell_q    <= cell_d;
      changed_q <= changed_d;
    end
  end

  assign bus.state_d = cell_d;
  assign bus.state_q = cell_q;
  assign bus.alive   = (cell_q == ONE);
  assign bus.changed = changed_q;

  // ---------------------------------------------------------------------------
  // Alive-age counter: counts consecutive generations alive, restarting at 1
  // on birth and saturating at all-ones.
  // ---------------------------------------------------------------------------
`ifdef LIFE_CELL_AGE_EN
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (bus.load) begin
      age_d = '0;
    end else if (bus.ena) begin
      if (rule_next != ONE) begin
        age_d = '0;
      end else if (cell_q != ONE) begin
        age_d = AGE_W'(1);
      end else if (age_q != AGE_MAX) begin
        age_d = age_q + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the asynchronous reset clears every state register, so a reset
    // mid-run leaves no partial generation behind.
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign bus.age = age_q;
`else
  assign bus.age = '0;
`endif

endmodule
